// File: rtl/fe_mul_arbiter_if.sv
// Requester and multiplier-facing bus of the shared fe_mulx arbiter.
interface fe_mul_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 320
);
  // Requester side
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_op_a;
  logic [NREQ*W-1:0] req_op_b;
  logic [NREQ-1:0]   req_done;
  logic [W-1:0]      res;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              err;

  // Multiplier side
  logic [W-1:0]      mul_op_a;
  logic [W-1:0]      mul_op_b;
  logic              mul_valid;
  logic [W-1:0]      mul_res;
  logic              mul_done;

  // Arbiter view
  modport slave (
    input  req_valid, req_op_a, req_op_b, mul_res, mul_done,
    output req_done, res, grant, busy, err, mul_op_a, mul_op_b, mul_valid
  );

  // Environment view (requesters plus multiplier)
  modport master (
    output req_valid, req_op_a, req_op_b, mul_res, mul_done,
    input  req_done, res, grant, busy, err, mul_op_a, mul_op_b, mul_valid
  );
endinterface

// File: rtl/fe_mul_arbiter.sv
// Round-robin arbiter sharing one fe_mulx multiplier among NREQ requesters,
// one operation in flight, with a sticky watchdog on multiplier hangs.
module fe_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 320,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  fe_mul_arbiter_if.slave bus
);

  localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]      state,       state_d;
  logic [RRW-1:0]  rr,          rr_d;
  logic [RRW-1:0]  owner,       owner_d;
  logic [WDW-1:0]  wd,          wd_d;
  logic [NREQ-1:0] grant_q,     grant_d;
  logic [NREQ-1:0] req_done_q,  req_done_d;
  logic [W-1:0]    res_q,       res_d;
  logic            busy_q,      busy_d;
  logic            err_q,       err_d;
  logic [W-1:0]    mul_a_q,     mul_a_d;
  logic [W-1:0]    mul_b_q,     mul_b_d;
  logic            mul_valid_q, mul_valid_d;

  logic            found_c;
  logic [RRW-1:0]  win_c;

  logic [W-1:0]    op_a_arr [NREQ];
  logic [W-1:0]    op_b_arr [NREQ];

  // Unpack the flat operand buses into per-requester slices
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign op_a_arr[g] = bus.req_op_a[g*W +: W];
    assign op_b_arr[g] = bus.req_op_b[g*W +: W];
  end

  // Round-robin pick: first pending requester at or above rr, wrapping
  always_comb begin : p_scan
    int unsigned idx;
    idx     = 0;
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found_c && bus.req_valid[RRW'(idx)]) begin
        found_c = 1'b1;
        win_c   = RRW'(idx);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    rr_d        = rr;
    owner_d     = owner;
    wd_d        = wd;
    grant_d     = grant_q;
    req_done_d  = '0;
    res_d       = res_q;
    busy_d      = busy_q;
    err_d       = err_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_valid_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (found_c) begin
          state_d     = ST_ISSUE;
          owner_d     = win_c;
          grant_d     = NREQ'(1) << win_c;
          mul_a_d     = op_a_arr[win_c];
          mul_b_d     = op_b_arr[win_c];
          busy_d      = 1'b1;
          mul_valid_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        rr_d    = (32'(owner) == NREQ - 1) ? '0 : owner + RRW'(1);
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mul_done) begin
          res_d      = bus.mul_res;
          req_done_d = grant_q;
          state_d    = ST_RESP;
        end else if (wd == WDW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          req_done_d = grant_q;
          state_d    = ST_RESP;
        end else begin
          wd_d = wd + WDW'(1);
        end
      end
      ST_RESP: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr          <= '0;
      owner       <= '0;
      wd          <= '0;
      grant_q     <= '0;
      req_done_q  <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      rr          <= rr_d;
      owner       <= owner_d;
      wd          <= wd_d;
      grant_q     <= grant_d;
      req_done_q  <= req_done_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_valid_q <= mul_valid_d;
    end
  end

  assign bus.req_done  = req_done_q;
  assign bus.res       = res_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.mul_op_a  = mul_a_q;
  assign bus.mul_op_b  = mul_b_q;
  assign bus.mul_valid = mul_valid_q;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Self-checking bench for fe_mul_arbiter: directed corner sequences, a
// contention table, and a randomized run against a timestamp-level model.
module tb_fe_mul_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 320;
  localparam int unsigned TIMEOUT = 8;

  logic clk;
  logic rst;

  fe_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  fe_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  logic [W-1:0] last_res;

  typedef struct {
    logic [NREQ-1:0] mask;
    int              n;
    int              order [4];
  } rec_t;

  rec_t tbl [8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".req_done"}, W'(bus.req_done), '0);
    chk({tag, ".grant"}, W'(bus.grant), '0);
    chk({tag, ".busy"}, W'(bus.busy), '0);
    chk({tag, ".mul_valid"}, W'(bus.mul_valid), '0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.mul_done  = 1'b0;
    tick();
    tick();
    chk_quiet(tag);
    chk({tag, ".err"}, W'(bus.err), '0);
    chk({tag, ".res"}, bus.res, '0);
    chk({tag, ".mul_op_a"}, bus.mul_op_a, '0);
    rst = 1'b0;
    last_res = '0;
  endtask

  // Called in the idle cycle where req_valid has just been driven; returns in the req_done cycle
  task automatic serve(input string tag, input int w, input int lat,
                       input logic [W-1:0] exp_a, input logic [W-1:0] exp_res);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << w;
    tick();
    chk({tag, ".mul_valid"}, W'(bus.mul_valid), W'(1));
    chk({tag, ".grant"}, W'(bus.grant), W'(oh));
    chk({tag, ".busy"}, W'(bus.busy), W'(1));
    chk({tag, ".mul_op_a"}, bus.mul_op_a, exp_a);
    for (int c = 0; c < lat; c++) begin
      tick();
      chk({tag, ".early_done"}, W'(bus.req_done), '0);
      chk({tag, ".mul_valid_low"}, W'(bus.mul_valid), '0);
      if (c == lat - 1) begin
        bus.mul_done = 1'b1;
        bus.mul_res  = bus.mul_op_a * bus.mul_op_b;
      end
    end
    tick();
    bus.mul_done = 1'b0;
    chk({tag, ".req_done"}, W'(bus.req_done), W'(oh));
    chk({tag, ".res"}, bus.res, exp_res);
    chk({tag, ".grant_resp"}, W'(bus.grant), W'(oh));
    last_res = exp_res;
  endtask

  task automatic run_random(input int ncyc);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] eg;
    logic [63:0]     oa [NREQ];
    logic [63:0]     ob [NREQ];
    logic [W-1:0]    prod;
    logic [W-1:0]    mres;
    int rr, win, dec, done, free_at, just;
    bit infl, active, found;
    pend = '0; rr = 0; win = 0; dec = 0; done = 0; free_at = 0;
    infl = 1'b0; mres = '0; prod = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      oa[i] = '0;
      ob[i] = '0;
    end
    for (int t = 0; t < ncyc; t++) begin
      tick();
      active = infl && (t >= dec + 1) && (t <= done + 1);
      eg = active ? (NREQ'(1) << win) : '0;
      if (infl && t == done + 1) mres = prod;
      chk("rnd.grant", W'(bus.grant), W'(eg));
      chk("rnd.busy", W'(bus.busy), W'(active));
      chk("rnd.mul_valid", W'(bus.mul_valid), W'(infl && t == dec + 1));
      chk("rnd.req_done", W'(bus.req_done), (infl && t == done + 1) ? W'(eg) : '0);
      chk("rnd.res", bus.res, mres);
      chk("rnd.err", W'(bus.err), '0);
      if (active) begin
        chk("rnd.mul_op_a", bus.mul_op_a, W'(oa[win]));
        chk("rnd.mul_op_b", bus.mul_op_b, W'(ob[win]));
      end
      // Requesters: served one drops the cycle after its done, others raise at random
      just = -1;
      if (infl && t == done + 2) begin
        pend[win] = 1'b0;
        just = win;
      end
      if (t < ncyc - 40) begin
        for (int i = 0; i < int'(NREQ); i++) begin
          if (!pend[i] && i != just && $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            oa[i] = {$urandom, $urandom};
            ob[i] = {$urandom, $urandom};
            bus.req_op_a[i*W +: W] = W'(oa[i]);
            bus.req_op_b[i*W +: W] = W'(ob[i]);
          end
        end
      end
      bus.req_valid = pend;
      // Model grant decision in an idle cycle
      if (t >= free_at && pend != '0) begin
        found = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
          if (!found && pend[(rr + k) % int'(NREQ)]) begin
            found = 1'b1;
            win = (rr + k) % int'(NREQ);
          end
        end
        rr = (win + 1) % int'(NREQ);
        dec = t;
        done = t + 1 + int'($urandom_range(1, 5));
        free_at = done + 2;
        infl = 1'b1;
        prod = W'(oa[win]) * W'(ob[win]);
      end
      // Multiplier stub with spurious pulses outside the wait window
      if (infl && t == done) begin
        bus.mul_done = 1'b1;
        bus.mul_res  = bus.mul_op_a * bus.mul_op_b;
      end else if (!(infl && t >= dec + 2 && t <= done) && $urandom_range(0, 7) == 0) begin
        bus.mul_done = 1'b1;
        bus.mul_res  = {10{$urandom}};
      end else begin
        bus.mul_done = 1'b0;
      end
    end
    bus.mul_done  = 1'b0;
    bus.req_valid = '0;
  endtask

  initial begin
    logic [NREQ-1:0] pending;
    vectors = 0;
    miscompares = 0;
    last_res = '0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op_a  = '0;
    bus.req_op_b  = '0;
    bus.mul_res   = '0;
    bus.mul_done  = 1'b0;

    // Reset, then idle for 10 cycles
    do_reset("reset");
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_quiet("idle");
      chk("idle.err", W'(bus.err), '0);
      chk("idle.res", bus.res, '0);
    end

    // Single request, 2*3, multiplier answers in the first wait cycle
    bus.req_op_a[0 +: W] = W'(2);
    bus.req_op_b[0 +: W] = W'(3);
    bus.req_valid = 4'b0001;
    serve("single", 0, 1, W'(2), W'(6));
    tick();
    bus.req_valid = '0;
    chk_quiet("single.after");

    // Single request with a slower multiplier
    tick();
    bus.req_op_a[0 +: W] = W'(5);
    bus.req_op_b[0 +: W] = W'(7);
    bus.req_valid = 4'b0001;
    serve("slow", 0, 4, W'(5), W'(35));
    tick();
    bus.req_valid = '0;
    chk_quiet("slow.after");

    // Contention table: requester i has op_a=i+1, op_b=1
    do_reset("reset2");
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_op_a[i*W +: W] = W'(i + 1);
      bus.req_op_b[i*W +: W] = W'(1);
    end
    tbl[0] = '{4'b1111, 4, '{0, 1, 2, 3}};
    tbl[1] = '{4'b0100, 1, '{2, 0, 0, 0}};
    tbl[2] = '{4'b0101, 2, '{0, 2, 0, 0}};
    tbl[3] = '{4'b0110, 2, '{1, 2, 0, 0}};
    tbl[4] = '{4'b1010, 2, '{3, 1, 0, 0}};
    tbl[5] = '{4'b1001, 2, '{3, 0, 0, 0}};
    tbl[6] = '{4'b0011, 2, '{1, 0, 0, 0}};
    tbl[7] = '{4'b1110, 3, '{1, 2, 3, 0}};
    for (int r = 0; r < 8; r++) begin
      tick();
      pending = tbl[r].mask;
      bus.req_valid = pending;
      for (int k = 0; k < tbl[r].n; k++) begin
        serve($sformatf("tbl%0d.op%0d", r, k), tbl[r].order[k], 1,
              W'(tbl[r].order[k] + 1), W'(tbl[r].order[k] + 1));
        pending[tbl[r].order[k]] = 1'b0;
        tick();
        bus.req_valid = pending;
        chk($sformatf("tbl%0d.gap%0d.grant", r, k), W'(bus.grant), '0);
        chk($sformatf("tbl%0d.gap%0d.busy", r, k), W'(bus.busy), '0);
      end
    end

    // Spurious multiplier done while idle
    tick();
    bus.mul_done = 1'b1;
    bus.mul_res  = {10{32'hdeadbeef}};
    tick();
    bus.mul_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk_quiet("spur");
      chk("spur.err", W'(bus.err), '0);
      chk("spur.res", bus.res, last_res);
      tick();
    end

    // Watchdog: multiplier never answers
    bus.req_op_a[1*W +: W] = W'(9);
    bus.req_op_b[1*W +: W] = W'(9);
    bus.req_valid = 4'b0010;
    tick();
    chk("wd.mul_valid", W'(bus.mul_valid), W'(1));
    chk("wd.grant", W'(bus.grant), W'(4'b0010));
    for (int c = 0; c < int'(TIMEOUT); c++) begin
      tick();
      chk("wd.no_done", W'(bus.req_done), '0);
      chk("wd.err_low", W'(bus.err), '0);
      chk("wd.busy", W'(bus.busy), W'(1));
    end
    tick();
    bus.req_valid = '0;
    chk("wd.req_done", W'(bus.req_done), W'(4'b0010));
    chk("wd.err", W'(bus.err), W'(1));
    chk("wd.res_kept", bus.res, last_res);
    tick();
    chk("wd.after.busy", W'(bus.busy), '0);
    chk("wd.after.err", W'(bus.err), W'(1));

    // Err stays set across a normal operation
    bus.req_op_a[0 +: W] = W'(3);
    bus.req_op_b[0 +: W] = W'(3);
    bus.req_valid = 4'b0001;
    serve("sticky", 0, 2, W'(3), W'(9));
    tick();
    bus.req_valid = '0;
    chk("sticky.err", W'(bus.err), W'(1));

    // Reset in the middle of a wait, colliding with mul_done
    tick();
    bus.req_op_a[2*W +: W] = W'(11);
    bus.req_valid = 4'b0100;
    tick();
    chk("midrst.mul_valid", W'(bus.mul_valid), W'(1));
    tick();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.mul_done  = 1'b1;
    bus.mul_res   = {10{32'h12345678}};
    tick();
    rst = 1'b0;
    bus.mul_done = 1'b0;
    chk_quiet("midrst");
    chk("midrst.err", W'(bus.err), '0);
    chk("midrst.res", bus.res, '0);
    chk("midrst.mul_op_a", bus.mul_op_a, '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_quiet("midrst.after");
    end

    // Randomized traffic against the reference model
    do_reset("reset3");
    run_random(600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fe_mul_arbiter.md
Name: fe_mul_arbiter

Overview:
- Shares one fe_mulx field multiplier among NREQ requesters (ge_frombytes_negate_vartime, ge point add/double sequencers, etc.).
- Each requester keeps its own mul_op_a/mul_op_b/mul_valid/mul_res/mul_done style interface. The arbiter grants round-robin and keeps one operation in flight.
- It registers operands, issues a single-cycle pulse to the multiplier, returns the product to the winner, and flags multiplier hangs through a watchdog.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 320, field-element width (10 x 32-bit limbs).
- TIMEOUT, 64, maximum WAIT cycles before the watchdog fires (>= 2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester level request; held high until its req_done.
- req_op_a  input  NREQ*W  requester i operand A at bits [i*W +: W]; stable while req_valid[i]=1.
- req_op_b  input  NREQ*W  requester i operand B, same packing.
- req_done  output  NREQ  one-hot single-cycle pulse: product ready for that requester.
- res  output  W  registered product; valid while req_done is high, held until the next RESP.
- grant  output  NREQ  one-hot owner of the multiplier; 0 in IDLE.
- busy  output  1  high in ISSUE, WAIT and RESP.
- err  output  1  sticky watchdog flag; cleared only by rst.
- mul_op_a  output  W  registered operand A to fe_mulx.
- mul_op_b  output  W  registered operand B to fe_mulx.
- mul_valid  output  1  single-cycle start pulse to fe_mulx.
- mul_res  input  W  fe_mulx product.
- mul_done  input  1  fe_mulx completion pulse.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, rr pointer=0, watchdog=0.
  - All outputs go to 0: req_done, res, grant, busy, err, mul_op_a, mul_op_b, mul_valid.
  - Reset wins over every other event, including mid-operation. The in-flight op is abandoned with no req_done.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit scanning from the rr pointer upward, wrapping modulo NREQ.
  - Register grant (one-hot), mul_op_a and mul_op_b from that slice, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mul_valid=1.
  - Set rr pointer = (winner+1) mod NREQ.
  - Clear watchdog, go to WAIT.
- WAIT:
  - mul_valid=0. mul_op_a/mul_op_b held stable.
  - If mul_done=1: res <= mul_res, go to RESP.
  - Else increment watchdog. When watchdog reaches TIMEOUT-1 without mul_done: err <= 1, res unchanged, go to RESP.
- RESP (exactly 1 cycle):
  - req_done[grant]=1, grant still valid. Next state IDLE, where grant clears.
- mul_done is sampled only in WAIT. A pulse in IDLE, ISSUE or RESP is ignored and does not affect err.
- Latency:
  - Request seen in IDLE at cycle 0 gives mul_valid in cycle 1.
  - mul_done at cycle k gives req_done and res at cycle k+1.
  - Earliest next grant decision is in cycle k+2.
- Requester contract: deassert req_valid in the cycle after its req_done. If it stays high, it is treated as a new request, subject to round-robin order.
- Requests arriving during busy wait. req_valid changes outside IDLE are not observed.
- Simultaneous requests: round-robin guarantees each pending requester is served within NREQ operations (no starvation).
- Exactly one grant bit is ever set, and at most one multiplication is outstanding.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles with req_valid=0. Assert rst mid-WAIT: state returns to IDLE, no req_done, grant=0.
- Single request: req_valid=4'b0001, op_a=320'h2, op_b=320'h3 with real fe_mulx. Required response:
  - mul_valid pulses 1 cycle after request.
  - req_done=4'b0001 exactly one cycle after mul_done.
  - res=320'h6, busy low the cycle after.
- Contention: req_valid=4'b1111 at once, each requester deasserting after its done. Required response:
  - req_done order is 0,1,2,3.
  - Requester i uses op_a=i+1, op_b=320'h1, so res = 1,2,3,4 respectively.
- Round-robin wrap: serve requester 2, then raise 4'b0101. Requester 0 is served before 2 (pointer=3 wraps to 0).
- Watchdog: stub multiplier never raises mul_done, TIMEOUT=8. Required response:
  - After mul_valid, err=1 and req_done pulses at cycle 1+8+1.
  - res keeps its previous value; err stays 1 until rst.
- Spurious done: pulse mul_done in IDLE with no requests. No req_done, err=0, res unchanged.
